stdp_weight_update: RTL and testbench

- Plasticity stage downstream of the LIF neuron.
- Consumes the presynaptic input spike and the neuron's output spike, and maintains decaying pre/post eligibility traces.
- Applies pair-based STDP (LTP/LTD) to one synaptic weight register.
- The weight feeds back as the neuron's input-current gain and is exposed for observation on the top-level outputs.

---
 rtl/stdp_weight_update.sv | 145 ++++++++++++++
 tb/tb_stdp_weight_update.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_weight_update.sv
`default_nettype none
// ============================================================================
// Module   : stdp_weight_update
// Purpose  : Pair-based STDP on one synaptic weight, driven by decaying
//            pre/post eligibility traces through a two-stage update pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module stdp_weight_update #(
    parameter int W_WIDTH     = 8,
    parameter int W_INIT      = 64,
    parameter int TRACE_WIDTH = 4,
    parameter int TRACE_MAX   = 15,
    parameter int A_PLUS      = 8,
    parameter int A_MINUS     = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   learn_en,
    input  logic                   pre_spike,
    input  logic                   post_spike,
    output logic [W_WIDTH-1:0]     weight,
    output logic                   weight_valid,
    output logic                   ltp_evt,
    output logic                   ltd_evt,
    output logic [TRACE_WIDTH-1:0] pre_trace,
    output logic [TRACE_WIDTH-1:0] post_trace
);

    localparam int                   c_prod_width = TRACE_WIDTH + W_WIDTH;
    localparam int                   c_net_width  = W_WIDTH + 2;
    localparam int                   c_sum_width  = W_WIDTH + 3;
    localparam logic [TRACE_WIDTH-1:0] c_trace_max = TRACE_WIDTH'(TRACE_MAX);
    localparam logic [W_WIDTH-1:0]   c_w_one      = W_WIDTH'(1);
    localparam logic [W_WIDTH-1:0]   c_w_max      = {W_WIDTH{1'b1}};

    logic [TRACE_WIDTH-1:0]   r_pre_trace;
    logic [TRACE_WIDTH-1:0]   r_post_trace;
    logic [W_WIDTH-1:0]       r_weight;
    logic                     r_weight_valid;
    logic                     r_ltp_evt;
    logic                     r_ltd_evt;
    logic                     r_upd;
    logic signed [c_net_width-1:0] r_net;

    logic                     w_ltp;
    logic                     w_ltd;
    logic [c_prod_width-1:0]  w_prod_plus;
    logic [c_prod_width-1:0]  w_prod_minus;
    logic [W_WIDTH-1:0]       w_mag_plus;
    logic [W_WIDTH-1:0]       w_mag_minus;
    logic [W_WIDTH-1:0]       w_dplus;
    logic [W_WIDTH-1:0]       w_dminus;
    logic signed [c_net_width-1:0] w_net;
    logic signed [c_sum_width-1:0] w_sum;
    logic [W_WIDTH-1:0]       w_weight_next;
    logic [TRACE_WIDTH-1:0]   w_pre_trace_next;
    logic [TRACE_WIDTH-1:0]   w_post_trace_next;

    // Stage 1: deltas come from the trace values held before this edge
    assign w_ltp        = post_spike && (r_pre_trace != '0);
    assign w_ltd        = pre_spike && (r_post_trace != '0);
    assign w_prod_plus  = c_prod_width'(r_pre_trace) * c_prod_width'(A_PLUS);
    assign w_prod_minus = c_prod_width'(r_post_trace) * c_prod_width'(A_MINUS);
    assign w_mag_plus   = w_prod_plus[c_prod_width-1:TRACE_WIDTH];
    assign w_mag_minus  = w_prod_minus[c_prod_width-1:TRACE_WIDTH];

    always_comb begin
        w_dplus  = '0;
        w_dminus = '0;
        if (w_ltp) begin
            w_dplus = (w_mag_plus == '0) ? c_w_one : w_mag_plus;
        end
        if (w_ltd) begin
            w_dminus = (w_mag_minus == '0) ? c_w_one : w_mag_minus;
        end
    end

    assign w_net = $signed({2'b00, w_dplus}) - $signed({2'b00, w_dminus});

    // Stage 2: saturating add of the registered net delta
    assign w_sum = $signed({3'b000, r_weight}) + $signed({r_net[c_net_width-1], r_net});

    always_comb begin
        w_weight_next = w_sum[W_WIDTH-1:0];
        if (w_sum < 0) begin
            w_weight_next = '0;
        end else if (w_sum > $signed({3'b000, c_w_max})) begin
            w_weight_next = c_w_max;
        end
    end

    always_comb begin
        w_pre_trace_next  = r_pre_trace;
        w_post_trace_next = r_post_trace;
        if (pre_spike) begin
            w_pre_trace_next = c_trace_max;
        end else if (r_pre_trace != '0) begin
            w_pre_trace_next = r_pre_trace - 1'b1;
        end
        if (post_spike) begin
            w_post_trace_next = c_trace_max;
        end else if (r_post_trace != '0) begin
            w_post_trace_next = r_post_trace - 1'b1;
        end
    end

    // With en low the pending stage-1 result is held, so it lands on the next enabled edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_trace    <= '0;
            r_post_trace   <= '0;
            r_weight       <= W_WIDTH'(W_INIT);
            r_weight_valid <= 1'b0;
            r_ltp_evt      <= 1'b0;
            r_ltd_evt      <= 1'b0;
            r_upd          <= 1'b0;
            r_net          <= '0;
        end else if (en) begin
            r_pre_trace    <= w_pre_trace_next;
            r_post_trace   <= w_post_trace_next;
            r_ltp_evt      <= w_ltp;
            r_ltd_evt      <= w_ltd;
            r_upd          <= learn_en && (w_ltp || w_ltd);
            r_net          <= w_net;
            r_weight_valid <= r_upd;
            if (r_upd) begin
                r_weight <= w_weight_next;
            end
        end else begin
            r_weight_valid <= 1'b0;
            r_ltp_evt      <= 1'b0;
            r_ltd_evt      <= 1'b0;
        end
    end

    assign weight       = r_weight;
    assign weight_valid = r_weight_valid;
    assign ltp_evt      = r_ltp_evt;
    assign ltd_evt      = r_ltd_evt;
    assign pre_trace    = r_pre_trace;
    assign post_trace   = r_post_trace;

endmodule
`default_nettype wire

// File: tb/tb_stdp_weight_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_stdp_weight_update
// Purpose  : Directed self-checking bench for stdp_weight_update.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stdp_weight_update;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       learn_en = 1'b1;
    logic       pre_spike = 1'b0;
    logic       post_spike = 1'b0;

    logic [7:0] weight;
    logic       weight_valid;
    logic       ltp_evt;
    logic       ltd_evt;
    logic [3:0] pre_trace;
    logic [3:0] post_trace;

    logic [7:0] s_weight;
    logic       s_weight_valid;
    logic       s_ltp_evt;
    logic       s_ltd_evt;
    logic [3:0] s_pre_trace;
    logic [3:0] s_post_trace;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stdp_weight_update dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .learn_en     (learn_en),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .weight       (weight),
        .weight_valid (weight_valid),
        .ltp_evt      (ltp_evt),
        .ltd_evt      (ltd_evt),
        .pre_trace    (pre_trace),
        .post_trace   (post_trace)
    );

    // Second build starting near the top of the range
    stdp_weight_update #(.W_INIT(250)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .learn_en     (learn_en),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .weight       (s_weight),
        .weight_valid (s_weight_valid),
        .ltp_evt      (s_ltp_evt),
        .ltd_evt      (s_ltd_evt),
        .pre_trace    (s_pre_trace),
        .post_trace   (s_post_trace)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input logic p, input logic q);
        pre_spike  = p;
        post_spike = q;
        @(posedge clk);
        #1;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset and idle
        do_reset();
        chk("rst_weight", weight, 64);
        chk("rst_pre_trace", pre_trace, 0);
        chk("rst_post_trace", post_trace, 0);
        chk("rst_valid", weight_valid, 0);
        chk("rst_sat_weight", s_weight, 250);
        idle(20);
        chk("idle_weight", weight, 64);
        chk("idle_valid", weight_valid, 0);

        // LTP: pre at e0, post at e3 sees pre_trace=13 -> +6
        tick(1, 0);
        idle(2);
        tick(0, 1);
        chk("ltp_evt", ltp_evt, 1);
        chk("ltp_pre_trace", pre_trace, 12);
        chk("ltp_weight_lat", weight, 64);
        tick(0, 0);
        chk("ltp_weight", weight, 70);
        chk("ltp_valid", weight_valid, 1);
        tick(0, 0);
        chk("ltp_valid_drop", weight_valid, 0);
        chk("ltp_weight_hold", weight, 70);
        do_reset();

        // LTD: post at e0, pre at e5 sees post_trace=11 -> -4
        tick(0, 1);
        idle(4);
        tick(1, 0);
        chk("ltd_evt", ltd_evt, 1);
        tick(0, 0);
        chk("ltd_weight", weight, 60);
        chk("ltd_valid", weight_valid, 1);
        do_reset();

        // Floor at trace=1, then expiry
        tick(1, 0);
        idle(14);
        tick(0, 1);
        chk("floor_evt", ltp_evt, 1);
        chk("floor_pre_trace", pre_trace, 0);
        tick(0, 1);
        chk("floor_weight", weight, 65);
        chk("floor_valid", weight_valid, 1);
        chk("expiry_evt", ltp_evt, 0);
        tick(0, 0);
        chk("expiry_valid", weight_valid, 0);
        chk("expiry_weight", weight, 65);
        do_reset();

        // Saturation at the top: 250+7 clamps to 255, then stays
        for (int i = 0; i < 2; i++) begin
            tick(1, 0);
            tick(0, 1);
            chk("sat_evt", s_ltp_evt, 1);
            tick(0, 0);
            chk("sat_weight", s_weight, 255);
            chk("sat_valid", s_weight_valid, 1);
            idle(18);
        end
        do_reset();

        // Repeated LTD (-5 each) pins the weight at 0
        for (int k = 1; k <= 14; k++) begin
            int exp_w;
            exp_w = 64 - 5 * k;
            if (exp_w < 0) exp_w = 0;
            tick(0, 1);
            tick(1, 0);
            tick(0, 0);
            chk("floor0_weight", weight, exp_w);
            chk("floor0_valid", weight_valid, 1);
            idle(18);
        end
        do_reset();

        // Simultaneous spikes with both traces at zero: no change
        tick(1, 1);
        chk("both0_ltp", ltp_evt, 0);
        chk("both0_ltd", ltd_evt, 0);
        chk("both0_pre_trace", pre_trace, 15);
        chk("both0_post_trace", post_trace, 15);
        tick(0, 0);
        chk("both0_valid", weight_valid, 0);
        chk("both0_weight", weight, 64);
        do_reset();

        // pre e0, post e1 (+7), pre+post e4: (12*8>>4) - (13*6>>4) = +2
        tick(1, 0);
        tick(0, 1);
        chk("sim_first_ltp", ltp_evt, 1);
        tick(0, 0);
        chk("sim_first_weight", weight, 71);
        tick(0, 0);
        tick(1, 1);
        chk("sim_ltp", ltp_evt, 1);
        chk("sim_ltd", ltd_evt, 1);
        chk("sim_pre_trace", pre_trace, 15);
        chk("sim_post_trace", post_trace, 15);
        tick(0, 0);
        chk("sim_weight", weight, 73);
        chk("sim_valid", weight_valid, 1);
        tick(0, 0);
        chk("sim_once", weight, 73);
        chk("sim_valid_drop", weight_valid, 0);
        do_reset();

        // Same sequence with learning off
        learn_en = 1'b0;
        tick(1, 0);
        tick(0, 1);
        chk("nolearn_ltp1", ltp_evt, 1);
        tick(0, 0);
        chk("nolearn_valid1", weight_valid, 0);
        tick(0, 0);
        tick(1, 1);
        chk("nolearn_ltp", ltp_evt, 1);
        chk("nolearn_ltd", ltd_evt, 1);
        tick(0, 0);
        chk("nolearn_weight", weight, 64);
        chk("nolearn_valid", weight_valid, 0);
        learn_en = 1'b1;
        do_reset();

        // en low between stages stalls the update
        tick(1, 0);
        idle(2);
        tick(0, 1);
        en = 1'b0;
        tick(0, 1);
        chk("stall_weight", weight, 64);
        chk("stall_valid", weight_valid, 0);
        chk("stall_evt", ltp_evt, 0);
        chk("stall_pre_trace", pre_trace, 12);
        en = 1'b1;
        tick(0, 0);
        chk("stall_apply_weight", weight, 70);
        chk("stall_apply_valid", weight_valid, 1);
        do_reset();

        // Reset between stages drops the update
        tick(1, 0);
        idle(2);
        tick(0, 1);
        rst = 1'b1;
        tick(0, 0);
        chk("drop_weight", weight, 64);
        chk("drop_valid", weight_valid, 0);
        rst = 1'b0;
        tick(0, 0);
        chk("drop_weight_after", weight, 64);
        chk("drop_valid_after", weight_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
